// File: rtl/uart_tx_if.sv
// Byte-stream handshake into the UART transmitter.
// The master drives tx_data/tx_valid. The slave (uart_tx) returns tx_ready.
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a small byte FIFO in front of it.
// Optional feature macro: UART_TX_PARITY_EN.
// When it is defined, an even-parity bit is inserted between the data bits and the stop bit.
// tx, tx_busy and tx_empty are registered copies of the FSM's view.
// They lag the state register by one clock, so a byte accepted at edge N drives the line low at edge N+2.
module uart_tx #(
  parameter int clk_freq   = 12000000,
  parameter int baud       = 115200,
  parameter int fifo_depth = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_tx_if.slave bus,
  output logic     tx,
  output logic     tx_busy,
  output logic     tx_empty
);
  localparam int BIT_CLKS = clk_freq / baud;
  localparam int TW       = $clog2(BIT_CLKS);
  localparam int AW       = $clog2(fifo_depth);
  localparam int CW       = AW + 1;

  localparam logic [TW-1:0] BIT_RELOAD = TW'(BIT_CLKS - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_FULL   = CW'(fifo_depth);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

`ifdef UART_TX_PARITY_EN
  // Even parity: the XOR of all data bits.
  function automatic logic even_parity(input logic [7:0] d);
    even_parity = ^d;
  endfunction
`endif

  // FIFO storage and occupancy
  logic [7:0]    mem_r [fifo_depth];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next_s;
  logic          ready_r;

  // Transmit FSM
  state_t        state_r;
  logic [TW-1:0] timer_r;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic          tx_r;
  logic          busy_r;
  logic          empty_r;
`ifdef UART_TX_PARITY_EN
  logic          parity_r;
`endif

  logic          push_s;
  logic          pop_s;
  logic          bit_end_s;
  logic          fifo_nonempty_s;
  logic          line_s;
  logic [7:0]    head_s;

  assign bus.tx_ready = ready_r;
  assign tx           = tx_r;
  assign tx_busy      = busy_r;
  assign tx_empty     = empty_r;
  assign head_s       = mem_r[rd_ptr_r];

  // Handshake, FSM pop request and next FIFO occupancy
  always_comb begin
    push_s          = bus.tx_valid && ready_r;
    bit_end_s       = (timer_r == {TW{1'b0}});
    fifo_nonempty_s = (count_r != {CW{1'b0}});
    pop_s           = 1'b0;
    if (state_r == ST_IDLE) begin
      pop_s = fifo_nonempty_s;
    end else if (state_r == ST_STOP) begin
      pop_s = bit_end_s && fifo_nonempty_s;
    end else begin
      pop_s = 1'b0;
    end
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Line level that the current state calls for
  always_comb begin
    line_s = 1'b1;
    case (state_r)
      ST_IDLE:   line_s = 1'b1;
      ST_START:  line_s = 1'b0;
      ST_DATA:   line_s = shift_r[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: line_s = parity_r;
`endif
      ST_STOP:   line_s = 1'b1;
      default:   line_s = 1'b1;
    endcase
  end

  // FIFO pointers, occupancy and registered ready; ready never sees tx_valid combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < fifo_depth; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      ready_r  <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= bus.tx_data;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_next_s;
      ready_r <= (count_next_s != CNT_FULL);
    end
  end

  // Frame sequencer plus the registered line and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      timer_r   <= {TW{1'b0}};
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
`ifdef UART_TX_PARITY_EN
      parity_r  <= 1'b0;
`endif
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
      empty_r   <= 1'b1;
    end else begin
      tx_r    <= line_s;
      busy_r  <= (state_r != ST_IDLE);
      empty_r <= (state_r == ST_IDLE) && !fifo_nonempty_s;
      case (state_r)
        ST_IDLE: begin
          if (fifo_nonempty_s) begin
            shift_r   <= head_s;
`ifdef UART_TX_PARITY_EN
            parity_r  <= even_parity(head_s);
`endif
            bit_cnt_r <= 3'd0;
            timer_r   <= BIT_RELOAD;
            state_r   <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end_s) begin
            timer_r <= BIT_RELOAD;
            state_r <= ST_DATA;
          end else begin
            timer_r <= timer_r - TIMER_ONE;
          end
        end
        ST_DATA: begin
          if (bit_end_s) begin
            timer_r <= BIT_RELOAD;
            shift_r <= {1'b0, shift_r[7:1]};
            if (bit_cnt_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_r <= ST_PARITY;
`else
              state_r <= ST_STOP;
`endif
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end else begin
            timer_r <= timer_r - TIMER_ONE;
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end_s) begin
            timer_r <= BIT_RELOAD;
            state_r <= ST_STOP;
          end else begin
            timer_r <= timer_r - TIMER_ONE;
          end
        end
`endif
        ST_STOP: begin
          if (bit_end_s) begin
            if (fifo_nonempty_s) begin
              // Next byte is already waiting: start bit follows the stop bit directly
              shift_r   <= head_s;
`ifdef UART_TX_PARITY_EN
              parity_r  <= even_parity(head_s);
`endif
              bit_cnt_r <= 3'd0;
              timer_r   <= BIT_RELOAD;
              state_r   <= ST_START;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            timer_r <= timer_r - TIMER_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          timer_r <= {TW{1'b0}};
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx.
// A cycle-exact loopback receiver decodes every frame.
// It compares each frame against a scoreboard of expected line words pushed at acceptance time.
module tb_uart_tx;
  localparam int CLK_FREQ   = 12000000;
  localparam int BAUD       = 115200;
  localparam int DEPTH      = 4;
  localparam int BIT_CLKS   = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CLKS = FRAME_BITS * BIT_CLKS;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // line bit i (LSB first) for the 8N1 frame
    logic       par;    // even parity of data
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic tx;
  logic tx_busy;
  logic tx_empty;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [10:0] sb_q[$];
  int          start_log[$];
  bit          rx_active = 1'b0;

  vec_t        tbl[9];
  logic [7:0]  burst[5];
  int          acc[5];
  int          acc_n;
  int          acc_m;
  int          idx;
  int          w;
  int          ready_hi;
  int          low_cnt;

  uart_tx_if bus();

  uart_tx #(
    .clk_freq  (CLK_FREQ),
    .baud      (BAUD),
    .fifo_depth(DEPTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_empty(tx_empty)
  );

  always #5 clk = ~clk;

  // Count rising edges; at a falling edge cyc equals the number of rising edges so far
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b0, 1'b1, d, 1'b0};
`endif
  endfunction

  function automatic logic [10:0] frame_of_vec(input vec_t v);
`ifdef UART_TX_PARITY_EN
    return {v.frame[9], v.par, v.frame[8:0]};
`else
    return {1'b0, v.frame};
`endif
  endfunction

  task automatic check_reset_state(input string tag);
    chk({tag, "_tx"}, 32'(tx), 32'd1);
    chk({tag, "_busy"}, 32'(tx_busy), 32'd0);
    chk({tag, "_empty"}, 32'(tx_empty), 32'd1);
    chk({tag, "_ready"}, 32'(bus.tx_ready), 32'd0);
  endtask

  // The caller is at a falling edge. Returns at the falling edge after the acceptance edge.
  task automatic push_byte(input logic [7:0] d, input logic [10:0] exp, output int acc_edge);
    int wt;
    wt = 0;
    acc_edge = -1;
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    while (bus.tx_ready !== 1'b1 && wt < 5000) begin
      @(negedge clk);
      wt++;
    end
    if (bus.tx_ready === 1'b1) begin
      sb_q.push_back(exp);
      acc_edge = cyc + 1;
    end else begin
      bound_fail("push_accept");
    end
    @(negedge clk);
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'($urandom);
  endtask

  task automatic wait_quiet(input string name, input int max_cyc);
    int wt;
    wt = 0;
    while ((sb_q.size() != 0 || rx_active) && wt < max_cyc) begin
      @(negedge clk);
      wt++;
    end
    if (sb_q.size() != 0 || rx_active) bound_fail(name);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_to_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Loopback receiver.
  // Samples every cycle of a frame and requires each bit to hold for its full period.
  initial begin : rx_proc
    logic [10:0] bits;
    logic [10:0] exp_w;
    bit          stable;
    bit          abort;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        rx_active = 1'b1;
        start_log.push_back(cyc);
        bits   = 11'd0;
        stable = 1'b1;
        abort  = 1'b0;
        for (int b = 0; b < FRAME_BITS && !abort; b++) begin
          for (int c = 0; c < BIT_CLKS && !abort; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (rst_n !== 1'b1) abort = 1'b1;
            else if (c == 0) bits[b] = tx;
            else if (tx !== bits[b]) stable = 1'b0;
          end
        end
        if (!abort) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx_unexpected: got frame %0h expected none", bits);
          end else begin
            exp_w = sb_q.pop_front();
            chk("rx_frame", 32'(bits), 32'(exp_w));
            chk("rx_bit_stable", 32'(stable), 32'd1);
          end
        end
        rx_active = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    tbl[0] = '{8'h55, 10'b1010101010, 1'b0};
    tbl[1] = '{8'h00, 10'b1000000000, 1'b0};
    tbl[2] = '{8'hFF, 10'b1111111110, 1'b0};
    tbl[3] = '{8'hA5, 10'b1101001010, 1'b0};
    tbl[4] = '{8'h80, 10'b1100000000, 1'b1};
    tbl[5] = '{8'h01, 10'b1000000010, 1'b1};
    tbl[6] = '{8'h3C, 10'b1001111000, 1'b0};
    tbl[7] = '{8'h07, 10'b1000001110, 1'b1};
    tbl[8] = '{8'h03, 10'b1000000110, 1'b0};
    burst  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};

    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;

    // Power-on reset: outputs forced while rst_n is low; ready rises on the first edge after release
    #1 rst_n = 1'b0;
    #2 check_reset_state("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_at_release", 32'(bus.tx_ready), 32'd0);
    @(negedge clk);
    chk("ready_first_edge", 32'(bus.tx_ready), 32'd1);
    chk("empty_after_por", 32'(tx_empty), 32'd1);

    // 0x55: start-bit latency, stop-bit end and tx_empty timing
    start_log.delete();
    push_byte(8'h55, frame_of(8'h55), acc_n);
    wait_to_cyc(acc_n + 1);
    chk("lat_n1_tx", 32'(tx), 32'd1);
    chk("lat_n1_empty", 32'(tx_empty), 32'd0);
    wait_to_cyc(acc_n + 2);
    chk("lat_n2_tx", 32'(tx), 32'd0);
    chk("lat_n2_busy", 32'(tx_busy), 32'd1);
    wait_to_cyc(acc_n + 1 + FRAME_CLKS);
    chk("end_minus1_empty", 32'(tx_empty), 32'd0);
    chk("end_minus1_busy", 32'(tx_busy), 32'd1);
    chk("end_minus1_tx", 32'(tx), 32'd1);
    wait_to_cyc(acc_n + 2 + FRAME_CLKS);
    chk("end_empty", 32'(tx_empty), 32'd1);
    chk("end_busy", 32'(tx_busy), 32'd0);
    wait_quiet("q55", 3000);
    if (start_log.size() == 0) bound_fail("start55");
    else chk("start55", 32'(start_log[0]), 32'(acc_n + 2));

    // Table of single bytes, each sent from idle
    for (int i = 0; i < 9; i++) begin
      start_log.delete();
      push_byte(tbl[i].data, frame_of_vec(tbl[i]), acc_n);
      wait_quiet("tbl_quiet", 3000);
      if (start_log.size() == 0) bound_fail("tbl_start");
      else chk("tbl_latency", 32'(start_log[0]), 32'(acc_n + 2));
      chk("tbl_empty", 32'(tx_empty), 32'd1);
    end

    // Burst of five bytes with tx_valid held, then 200 stalled cycles with changing tx_data
    start_log.delete();
    bus.tx_valid = 1'b1;
    bus.tx_data  = burst[0];
    idx = 0;
    w   = 0;
    while (idx < 5 && w < 200) begin
      if (bus.tx_ready === 1'b1) begin
        sb_q.push_back(frame_of(burst[idx]));
        acc[idx] = cyc + 1;
        idx++;
      end
      @(negedge clk);
      w++;
      if (idx < 5) bus.tx_data = burst[idx];
    end
    if (idx < 5) bound_fail("burst_accept");
    chk("burst_ready_low", 32'(bus.tx_ready), 32'd0);
    chk("burst_span", 32'(acc[4] - acc[0]), 32'd4);
    ready_hi = 0;
    for (int k = 0; k < 200; k++) begin
      bus.tx_data = 8'($urandom);
      if (bus.tx_ready === 1'b1) begin
        ready_hi++;
        sb_q.push_back(frame_of(bus.tx_data));
      end
      @(negedge clk);
    end
    chk("stall_ready_high", 32'(ready_hi), 32'd0);
    bus.tx_valid = 1'b0;
    push_byte(8'h5A, frame_of(8'h5A), acc_n);
    wait_quiet("burst_quiet", 9000);
    chk("burst_frames", 32'(start_log.size()), 32'd6);
    if (start_log.size() == 6) begin
      chk("burst_first_start", 32'(start_log[0]), 32'(acc[0] + 2));
      for (int k = 0; k < 5; k++) begin
        chk("burst_gap", 32'(start_log[k + 1] - start_log[k]), 32'(FRAME_CLKS));
      end
    end

    // A byte pushed on the very edge where the stop bit ends starts from idle
    start_log.delete();
    push_byte(8'hC3, frame_of(8'hC3), acc_n);
    wait_to_cyc(acc_n + FRAME_CLKS);
    push_byte(8'h3C, frame_of(8'h3C), acc_m);
    chk("stop_edge_accept", 32'(acc_m), 32'(acc_n + 1 + FRAME_CLKS));
    wait_quiet("stop_edge_quiet", 4000);
    chk("stop_edge_frames", 32'(start_log.size()), 32'd2);
    if (start_log.size() == 2) begin
      chk("stop_edge_latency", 32'(start_log[1]), 32'(acc_m + 2));
    end

    // Reset in the middle of 0xA5, with two more bytes queued behind it
    push_byte(8'hA5, frame_of(8'hA5), acc_n);
    push_byte(8'h11, frame_of(8'h11), acc_m);
    push_byte(8'h22, frame_of(8'h22), acc_m);
    wait_to_cyc(acc_n + 300);
    chk("pre_reset_line", 32'(tx), 32'd0);
    #3 rst_n = 1'b0;
    sb_q.delete();
    #1 check_reset_state("mid");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_ready_after", 32'(bus.tx_ready), 32'd1);
    low_cnt = 0;
    for (int k = 0; k < 1500; k++) begin
      if (tx !== 1'b1 || tx_empty !== 1'b1) low_cnt++;
      @(negedge clk);
    end
    chk("post_reset_idle", 32'(low_cnt), 32'd0);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
